// File: rtl/button_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int DEF_DEBOUNCE_CYCLES   = 500000;
  localparam int DEF_LONG_PRESS_CYCLES = 50000000;
  localparam int DEF_CNT_W             = 26;

endpackage

// File: rtl/button_debounce_if.sv
// Bundle of the button pad and its conditioned outputs, with driver/consumer views.
interface button_debounce_if;

  logic button_in;
  logic button_out;
  logic press_pulse;
  logic release_pulse;
  logic long_press;

  modport master (
    output button_in,
    input  button_out,
    input  press_pulse,
    input  release_pulse,
    input  long_press
  );

  modport slave (
    input  button_in,
    output button_out,
    output press_pulse,
    output release_pulse,
    output long_press
  );

endinterface

// File: rtl/button_sync.sv
// Two-flop synchroniser for one asynchronous pad; resets to 0 (released).
module button_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic s1_d, s1_q;
  logic s2_d, s2_q;

  // Shift chain next-state.
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  // Synchroniser flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/button_debounce.sv
// Debounces one raw push-button: synchronise, qualify with a stability counter,
// and emit a clean level, press/release strobes and a long-press flag.
module button_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int CNT_W             = DEF_CNT_W,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button_in,
  output logic button_out,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_CNT = CNT_W'(LONG_PRESS_CYCLES);

  logic raw_s;
  logic sync_s;

  btn_state_e       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [CNT_W-1:0] hold_d, hold_q;
  logic [CNT_W-1:0] hold_inc_s;
  logic             out_d, out_q;
  logic             press_d, press_q;
  logic             rel_d, rel_q;
  logic             long_d, long_q;

  assign raw_s = (ACTIVE_LOW != 0) ? ~button_in : button_in;

  button_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (raw_s),
    .q       (sync_s)
  );

  // Saturating hold counter increment; it stops at the long-press threshold.
  always_comb begin
    if (hold_q == LONG_CNT) begin
      hold_inc_s = hold_q;
    end else begin
      hold_inc_s = hold_q + CNT_ONE;
    end
  end

  // FSM and counter next-state; strobes default low so they last one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    out_d   = out_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = long_q;

    case (state_q)
      RELEASED: begin
        hold_d = CNT_ZERO;
        long_d = 1'b0;
        out_d  = 1'b0;
        if (sync_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end

      PRESS_WAIT: begin
        if (!sync_s) begin
          state_d = RELEASED;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == DEB_LAST) begin
          state_d = PRESSED;
          out_d   = 1'b1;
          press_d = 1'b1;
          cnt_d   = CNT_ZERO;
          hold_d  = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      PRESSED: begin
        hold_d = hold_inc_s;
        long_d = long_q | (hold_inc_s == LONG_CNT);
        if (!sync_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end

      RELEASE_WAIT: begin
        if (sync_s) begin
          // Release bounce: the hold keeps counting as if never interrupted.
          state_d = PRESSED;
          cnt_d   = CNT_ZERO;
          hold_d  = hold_inc_s;
          long_d  = long_q | (hold_inc_s == LONG_CNT);
        end else if (cnt_q == DEB_LAST) begin
          state_d = RELEASED;
          out_d   = 1'b0;
          rel_d   = 1'b1;
          long_d  = 1'b0;
          hold_d  = CNT_ZERO;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          hold_d  = hold_inc_s;
          long_d  = long_q | (hold_inc_s == LONG_CNT);
        end
      end

      default: begin
        state_d = RELEASED;
        cnt_d   = CNT_ZERO;
        hold_d  = CNT_ZERO;
        out_d   = 1'b0;
        long_d  = 1'b0;
      end
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= RELEASED;
      cnt_q   <= CNT_ZERO;
      hold_q  <= CNT_ZERO;
      out_q   <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
    end
  end

  assign button_out    = out_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_press    = long_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed table-driven bench for button_debounce (DEBOUNCE=4, LONG=10, CNT_W=8, active-low pad).
module tb_button_debounce;

  typedef struct {
    logic btn;
    logic rst_n;
    logic exp_out;
    logic exp_pp;
    logic exp_rp;
    logic exp_lp;
  } vec_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  int   step_idx;
  vec_t vecs[$];

  button_debounce_if bif ();

  button_debounce #(
    .DEBOUNCE_CYCLES   (4),
    .LONG_PRESS_CYCLES (10),
    .CNT_W             (8),
    .ACTIVE_LOW        (1)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .button_in     (bif.button_in),
    .button_out    (bif.button_out),
    .press_pulse   (bif.press_pulse),
    .release_pulse (bif.release_pulse),
    .long_press    (bif.long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input int n, input logic btn, input logic rst_n,
                     input logic o, input logic pp, input logic rp, input logic lp);
    vec_t v;
    v.btn = btn; v.rst_n = rst_n;
    v.exp_out = o; v.exp_pp = pp; v.exp_rp = rp; v.exp_lp = lp;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check1(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%b want=%b", name, idx, act, exp);
    end
  endtask

  // Drive inputs, take one clock edge, then compare all four outputs.
  task automatic step_check(input logic btn, input logic rst_n,
                            input logic o, input logic pp, input logic rp, input logic lp);
    bif.button_in = btn;
    reset_n       = rst_n;
    @(posedge clk);
    #1;
    check1("button_out",    step_idx, bif.button_out,    o);
    check1("press_pulse",   step_idx, bif.press_pulse,   pp);
    check1("release_pulse", step_idx, bif.release_pulse, rp);
    check1("long_press",    step_idx, bif.long_press,    lp);
    step_idx++;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    step_idx = 0;
    bif.button_in = 1'b1;
    reset_n       = 1'b0;

    // Reset with pad held pressed, then acceptance 5 edges after release of reset.
    add(3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    // Hold: long_press rises when hold reaches 10, then stays through saturation.
    add(9,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add(11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    // Clean release: five edges later, release_pulse with long_press dropping.
    add(5,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    add(1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    add(2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Bounce: low 3, high 1, low 2, then high; nothing is accepted.
    add(3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(6,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Clean press from idle.
    add(5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    add(2,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      step_check(vecs[i].btn, vecs[i].rst_n, vecs[i].exp_out,
                 vecs[i].exp_pp, vecs[i].exp_rp, vecs[i].exp_lp);
    end

    // Release bounce while pressed (hold is now 2): two high pad cycles must not
    // release nor restart the hold, so long_press still rises at hold 10.
    for (int k = 3; k <= 14; k++) begin
      step_check((k == 3 || k == 4), 1'b1, 1'b1, 1'b0, 1'b0, (k >= 10));
    end

    // Reset mid-hold: everything clears at once, no release strobe afterwards.
    step_check(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step_check(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
